// File: rtl/ysyx_22041211_bus_pkg.sv
// Shared FSM states, default address windows and bus field widths for the request router.
// Imported by the address decoder, the router top and anything that needs the same widths.
package ysyx_22041211_bus_pkg;

  localparam int unsigned BUS_DATA_LEN  = 32;
  localparam int unsigned BUS_ADDR_LEN  = 32;
  localparam int unsigned BUS_WMASK_LEN = BUS_DATA_LEN / 8;

  localparam logic [BUS_ADDR_LEN-1:0] T0_BASE_DEF = 32'h8000_0000;
  localparam logic [BUS_ADDR_LEN-1:0] T0_MASK_DEF = 32'hf800_0000;
  localparam logic [BUS_ADDR_LEN-1:0] T1_BASE_DEF = 32'ha000_0000;
  localparam logic [BUS_ADDR_LEN-1:0] T1_MASK_DEF = 32'hf000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } route_state_e;

endpackage

// File: rtl/ysyx_22041211_req_route_if.sv
// Request/response bus bundle: master drives the request and accepts the response, slave the reverse.
// Used for the upstream port and both downstream target ports of the router.
interface ysyx_22041211_req_route_if #(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned ADDR_LEN = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_LEN-1:0]   req_addr;
  logic [DATA_LEN-1:0]   req_wdata;
  logic                  req_wen;
  logic [DATA_LEN/8-1:0] req_wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_LEN-1:0]   rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_wen, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wen, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ysyx_22041211_addr_dec.sv
// Combinational address decoder: key=1 selects target 1 (priority), hit=0 means no target owns it.
// With YSYX_22041211_DECERR_EN undefined every address hits and non-target-1 traffic goes to target 0.
module ysyx_22041211_addr_dec
  import ysyx_22041211_bus_pkg::*;
#(
  parameter int unsigned         ADDR_LEN = BUS_ADDR_LEN,
  parameter logic [ADDR_LEN-1:0] T0_BASE  = T0_BASE_DEF,
  parameter logic [ADDR_LEN-1:0] T0_MASK  = T0_MASK_DEF,
  parameter logic [ADDR_LEN-1:0] T1_BASE  = T1_BASE_DEF,
  parameter logic [ADDR_LEN-1:0] T1_MASK  = T1_MASK_DEF
) (
  input  logic [ADDR_LEN-1:0] addr,
  output logic                key,
  output logic                hit
);

`ifdef YSYX_22041211_DECERR_EN
  localparam bit CHECK_T0 = 1'b1;
`else
  localparam bit CHECK_T0 = 1'b0;
`endif

  logic t0_match;

  assign key      = ((addr & T1_MASK) == T1_BASE);
  assign t0_match = ((addr & T0_MASK) == T0_BASE);
  assign hit      = key | t0_match | ~CHECK_T0;

endmodule

// File: rtl/ysyx_22041211_req_route.sv
// Single-outstanding 1:2 request router; accept->downstream valid 1 cycle, min round trip 4 cycles.
// Holds each stage until its handshake completes; decode errors (YSYX_22041211_DECERR_EN) answer directly.
module ysyx_22041211_req_route
  import ysyx_22041211_bus_pkg::*;
#(
  parameter int unsigned         DATA_LEN = BUS_DATA_LEN,
  parameter int unsigned         ADDR_LEN = BUS_ADDR_LEN,
  parameter logic [ADDR_LEN-1:0] T0_BASE  = T0_BASE_DEF,
  parameter logic [ADDR_LEN-1:0] T0_MASK  = T0_MASK_DEF,
  parameter logic [ADDR_LEN-1:0] T1_BASE  = T1_BASE_DEF,
  parameter logic [ADDR_LEN-1:0] T1_MASK  = T1_MASK_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ysyx_22041211_req_route_if.slave   up,
  ysyx_22041211_req_route_if.master  t0,
  ysyx_22041211_req_route_if.master  t1
);

  typedef struct packed {
    logic [ADDR_LEN-1:0]   addr;
    logic [DATA_LEN-1:0]   wdata;
    logic                  wen;
    logic [DATA_LEN/8-1:0] wmask;
  } req_t;

  typedef struct packed {
    logic [DATA_LEN-1:0] rdata;
    logic                err;
  } rsp_t;

  route_state_e state_q, state_d;
  logic         key_q, key_d;
  req_t         req_q, req_d;
  rsp_t         rsp_q, rsp_d;

  logic dec_key;
  logic dec_hit;
  logic sel_req_ready;
  logic sel_rsp_valid;
  rsp_t sel_rsp;

  ysyx_22041211_addr_dec #(
    .ADDR_LEN (ADDR_LEN),
    .T0_BASE  (T0_BASE),
    .T0_MASK  (T0_MASK),
    .T1_BASE  (T1_BASE),
    .T1_MASK  (T1_MASK)
  ) u_addr_dec (
    .addr (up.req_addr),
    .key  (dec_key),
    .hit  (dec_hit)
  );

  assign sel_req_ready = key_q ? t1.req_ready : t0.req_ready;
  assign sel_rsp_valid = key_q ? t1.rsp_valid : t0.rsp_valid;
  assign sel_rsp.rdata = key_q ? t1.rsp_rdata : t0.rsp_rdata;
  assign sel_rsp.err   = key_q ? t1.rsp_err   : t0.rsp_err;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (up.req_valid) begin
          req_d.addr  = up.req_addr;
          req_d.wdata = up.req_wdata;
          req_d.wen   = up.req_wen;
          req_d.wmask = up.req_wmask;
          key_d       = dec_key;
          if (dec_hit) begin
            state_d = ST_FWD;
          end else begin
            // Unowned address: answer immediately without touching either target.
            rsp_d.rdata = '0;
            rsp_d.err   = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end
      ST_FWD: begin
        if (sel_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sel_rsp_valid) begin
          rsp_d.rdata = req_q.wen ? '0 : sel_rsp.rdata;
          rsp_d.err   = sel_rsp.err;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (up.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= 1'b0;
      req_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
    end
  end

  // Every handshake output is a decode of registered state, so reset clears them asynchronously.
  assign up.req_ready = (state_q == ST_IDLE);
  assign up.rsp_valid = (state_q == ST_RESP);
  assign up.rsp_rdata = rsp_q.rdata;
  assign up.rsp_err   = rsp_q.err;

  assign t0.req_valid = (state_q == ST_FWD)  && !key_q;
  assign t1.req_valid = (state_q == ST_FWD)  &&  key_q;
  assign t0.rsp_ready = (state_q == ST_WAIT) && !key_q;
  assign t1.rsp_ready = (state_q == ST_WAIT) &&  key_q;

  assign t0.req_addr  = req_q.addr;
  assign t0.req_wdata = req_q.wdata;
  assign t0.req_wen   = req_q.wen;
  assign t0.req_wmask = req_q.wmask;
  assign t1.req_addr  = req_q.addr;
  assign t1.req_wdata = req_q.wdata;
  assign t1.req_wen   = req_q.wen;
  assign t1.req_wmask = req_q.wmask;

endmodule
